// File: rtl/ascon_perm_seq.sv
// ascon_perm_seq: iterative Ascon permutation engine.
//   Loads a 320-bit state (x0..x4) on an accepted start and then applies one
//   ascon_p round per clock for a run-time round count (1..12; 0 or >12 is
//   treated as 12), generating the round constants internally.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               load x*_in and begin; ignored while busy
//   rounds[3:0]         round count n
//   x0_in..x4_in[63:0]  initial state words, sampled with start
//   x0_out..x4_out      state register contents
//   busy                permutation in progress
//   done                one-cycle pulse, final state on x*_out
//
// ascon_p: one combinational Ascon round (constant addition, 5-bit S-box
// layer in bitsliced form, linear diffusion layer).
//   rc_i[7:0]  round constant, XORed into the low byte of x2
//   s_i, s_o   state in/out, word k at index k

module ascon_p (
  input  logic [7:0]       rc_i,
  input  logic [4:0][63:0] s_i,
  output logic [4:0][63:0] s_o
);

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned r);
    return (v >> r) | (v << (64 - r));
  endfunction

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = s_i[0];
    x1 = s_i[1];
    x2 = s_i[2] ^ {56'd0, rc_i};
    x3 = s_i[3];
    x4 = s_i[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    s_o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    s_o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    s_o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    s_o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    s_o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
  end

endmodule

module ascon_perm_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  rounds,
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [4:0][63:0] s_q, s_d;
  logic             done_q, done_d;
  logic [3:0]       n_eff;
  logic [7:0]       rc;
  logic [4:0][63:0] p_out;

  assign n_eff = ((rounds == 4'd0) || (rounds > 4'd12)) ? 4'd12 : rounds;
  assign rc    = {4'hF - idx_q, idx_q};

  ascon_p u_round (
    .rc_i (rc),
    .s_i  (s_q),
    .s_o  (p_out)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    s_d     = s_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = {x4_in, x3_in, x2_in, x1_in, x0_in};
          // An n-round permutation uses the last n constants (12-n..11).
          idx_d   = 4'd12 - n_eff;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d   = p_out;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd11) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign x0_out = s_q[0];
  assign x1_out = s_q[1];
  assign x2_out = s_q[2];
  assign x3_out = s_q[3];
  assign x4_out = s_q[4];

endmodule

// File: tb/tb_ascon_perm_seq.sv
// Testbench for ascon_perm_seq. The reference model applies the Ascon
// permutation column-wise through the 5-bit S-box table.
module tb_ascon_perm_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rounds = 4'd0;
  logic [63:0] x0_in = '0, x1_in = '0, x2_in = '0, x3_in = '0, x4_in = '0;
  logic [63:0] x0_out, x1_out, x2_out, x3_out, x4_out;
  logic        busy, done;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  ascon_perm_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .rounds (rounds),
    .x0_in  (x0_in),
    .x1_in  (x1_in),
    .x2_in  (x2_in),
    .x3_in  (x3_in),
    .x4_in  (x4_in),
    .x0_out (x0_out),
    .x1_out (x1_out),
    .x2_out (x2_out),
    .x3_out (x3_out),
    .x4_out (x4_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int unsigned ROT1 [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT2 [5] = '{28, 39, 6, 17, 41};

  function automatic int unsigned eff(input logic [3:0] r);
    return (r == 0 || r > 12) ? 12 : int'(r);
  endfunction

  function automatic logic [7:0] rc_of(input int unsigned i);
    return 8'((15 - i) * 16 + i);
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned r);
    return (v >> r) | (v << (64 - r));
  endfunction

  function automatic logic [4:0][63:0] model_round(input logic [4:0][63:0] s,
                                                   input int unsigned i);
    logic [4:0][63:0] t;
    logic [4:0]       col, sub;
    s[2][7:0] = s[2][7:0] ^ rc_of(i);
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      sub = SBOX[col];
      for (int k = 0; k < 5; k++) t[k][b] = sub[4-k];
    end
    for (int k = 0; k < 5; k++)
      t[k] = t[k] ^ rotr(t[k], ROT1[k]) ^ rotr(t[k], ROT2[k]);
    return t;
  endfunction

  function automatic logic [4:0][63:0] model_perm(input logic [4:0][63:0] s,
                                                  input logic [3:0] r);
    int unsigned n;
    n = eff(r);
    for (int unsigned i = 12 - n; i < 12; i++) s = model_round(s, i);
    return s;
  endfunction

  function automatic logic [4:0][63:0] rand_state();
    logic [4:0][63:0] s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_inputs(input logic [4:0][63:0] s);
    x0_in = s[0]; x1_in = s[1]; x2_in = s[2]; x3_in = s[3]; x4_in = s[4];
  endtask

  // Called at a negedge: presents a start for the next rising edge.
  task automatic launch(input logic [3:0] r, input logic [4:0][63:0] s);
    rounds = r;
    drive_inputs(s);
    start = 1'b1;
  endtask

  task automatic chk_words(input string tag, input logic [4:0][63:0] exp);
    logic [4:0][63:0] outs;
    outs = {x4_out, x3_out, x2_out, x1_out, x0_out};
    for (int w = 0; w < 5; w++) chk($sformatf("%s x%0d", tag, w), outs[w], exp[w]);
  endtask

  // Follows a launched run up to its done cycle, leaving the bench at the
  // negedge where done is high so a back-to-back start can be presented.
  task automatic wait_done(input string tag, input logic [3:0] r,
                           input logic [4:0][63:0] exp, input bit chk_rc,
                           input bit inject);
    int unsigned n, k, bcnt;
    n = eff(r);
    k = 0;
    bcnt = 0;
    @(negedge clk);
    start = 1'b0;
    drive_inputs(rand_state());
    while (done !== 1'b1 && k < 30) begin
      if (chk_rc && k < n)
        chk($sformatf("%s rc%0d", tag, k), 64'(dut.rc), 64'(rc_of(12 - n + k)));
      if (busy === 1'b1) bcnt++;
      if (inject && k == 2) begin
        drive_inputs(rand_state());
        rounds = 4'd1;
        start = 1'b1;
      end
      if (inject && k == 3) start = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(n));
    chk({tag, " busy cycles"}, 64'(bcnt), 64'(n));
    chk({tag, " busy at done"}, 64'(busy), 64'd0);
    chk_words(tag, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0][63:0] iv, sa, sb, ea, eb;
    logic [3:0] r;
    bit saw_done;

    iv = '0;
    iv[0] = 64'h80400c0600000000;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk_words("reset", '0);
    rst_n = 1'b1;

    // Single round, started on the first edge after release
    launch(4'd1, iv);
    wait_done("r1", 4'd1, model_perm(iv, 4'd1), 1'b1, 1'b0);

    // p^a and its out-of-range aliases
    @(negedge clk);
    chk_words("hold idle", model_perm(iv, 4'd1));
    launch(4'd12, iv);
    wait_done("r12", 4'd12, model_perm(iv, 4'd12), 1'b1, 1'b0);
    @(negedge clk);
    launch(4'd0, iv);
    wait_done("r0", 4'd0, model_perm(iv, 4'd12), 1'b0, 1'b0);
    @(negedge clk);
    launch(4'd15, iv);
    wait_done("r15", 4'd15, model_perm(iv, 4'd12), 1'b0, 1'b0);

    // p^b lengths with constant-sequence probe
    sa = rand_state();
    @(negedge clk);
    launch(4'd6, sa);
    wait_done("r6", 4'd6, model_perm(sa, 4'd6), 1'b1, 1'b0);
    sa = rand_state();
    @(negedge clk);
    launch(4'd8, sa);
    wait_done("r8", 4'd8, model_perm(sa, 4'd8), 1'b1, 1'b0);

    // Random round counts and states
    for (int t = 0; t < 6; t++) begin
      sa = rand_state();
      r = 4'($urandom_range(0, 15));
      @(negedge clk);
      launch(r, sa);
      wait_done($sformatf("rand%0d", t), r, model_perm(sa, r), 1'b0, 1'b0);
    end

    // Start while busy is ignored
    sa = rand_state();
    @(negedge clk);
    launch(4'd12, sa);
    wait_done("busy start", 4'd12, model_perm(sa, 4'd12), 1'b0, 1'b1);

    // Back-to-back: second start presented in the done cycle
    sa = rand_state();
    sb = rand_state();
    ea = model_perm(sa, 4'd6);
    eb = model_perm(sb, 4'd8);
    @(negedge clk);
    launch(4'd6, sa);
    wait_done("b2b first", 4'd6, ea, 1'b0, 1'b0);
    launch(4'd8, sb);
    wait_done("b2b second", 4'd8, eb, 1'b0, 1'b0);

    // Reset mid-run aborts cleanly
    sa = rand_state();
    @(negedge clk);
    launch(4'd12, sa);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk_words("abort", '0);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (busy !== 1'b0) saw_done = 1'b1;
    end
    chk("abort no done/busy", 64'(saw_done), 64'd0);
    rst_n = 1'b1;
    sa = rand_state();
    launch(4'd12, sa);
    wait_done("after abort", 4'd12, model_perm(sa, 4'd12), 1'b0, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
